multicycle_ctrl: RTL

- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the immediate-extension unit's imm_type select, plus the PC, IR, ALU-operand, memory and register-file enables.
- Owns the single unified memory port handshake and traps on illegal opcodes or memory timeout.

---
 rtl/multicycle_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_opcode_classify.sv | 57 +++++
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path:
// states, opcodes, instruction classes and datapath selector codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILL,
        C_OP,
        C_OPIMM,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC
    } cls_t;

    typedef enum logic [2:0] {
        RTYPE = 3'd0,
        ITYPE = 3'd1,
        STYPE = 3'd2,
        BTYPE = 3'd3,
        UTYPE = 3'd4,
        JTYPE = 3'd5
    } imm_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_ALU = 2'd1} pc_sel_t;
    typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} src_a_t;
    typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} src_b_t;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_t;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_opcode_classify.sv
// Combinational opcode decoder: instruction class, immediate
// format and legality for the control FSM.
module opcode_classify
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output imm_t       imm,
    output logic       legal
);

    always_comb begin
        cls   = C_ILL;
        imm   = RTYPE;
        legal = 1'b1;
        case (opcode)
            OPC_OP: begin
                cls = C_OP;
                imm = RTYPE;
            end
            OPC_OP_IMM: begin
                cls = C_OPIMM;
                imm = ITYPE;
            end
            OPC_LOAD: begin
                cls = C_LOAD;
                imm = ITYPE;
            end
            OPC_JALR: begin
                cls = C_JALR;
                imm = ITYPE;
            end
            OPC_STORE: begin
                cls = C_STORE;
                imm = STYPE;
            end
            OPC_BRANCH: begin
                cls = C_BRANCH;
                imm = BTYPE;
            end
            OPC_LUI: begin
                cls = C_LUI;
                imm = UTYPE;
            end
            OPC_AUIPC: begin
                cls = C_AUIPC;
                imm = UTYPE;
            end
            OPC_JAL: begin
                cls = C_JAL;
                imm = JTYPE;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: FETCH/DECODE/EXEC/
// MEM/WB sequencing, unified memory handshake, timeout and illegal traps.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic [2:0] imm_type,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       ir_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       trap,
    output logic [2:0] state_o
);

    localparam bit TO_EN = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LIM =
        TO_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

    state_t          state;
    state_t          nxt;
    cls_t            cls_q;
    cls_t            cls_d;
    imm_t            imm_q;
    imm_t            imm_d;
    logic            legal;
    logic [TO_W-1:0] cnt;
    logic            waiting;
    logic            to_hit;
    logic            trap_q;
    logic            unused;

    // Branch compare is done in the datapath; funct3 is not needed here.
    assign unused = ^funct3;

    opcode_classify u_cls (
        .opcode (opcode),
        .cls    (cls_d),
        .imm    (imm_d),
        .legal  (legal)
    );

    assign waiting = (state == S_FETCH || state == S_MEM) && !mem_ready;
    assign to_hit  = TO_EN && waiting && (cnt == TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            cnt    <= '0;
            cls_q  <= C_ILL;
            imm_q  <= RTYPE;
            trap_q <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state)
                cnt <= '0;
            else if (waiting)
                cnt <= cnt + TO_W'(1);
            // IR is stable only from DECODE onwards
            if (state == S_DECODE) begin
                cls_q <= cls_d;
                imm_q <= imm_d;
            end
            if (nxt == S_HALT && state != S_HALT)
                trap_q <= 1'b1;
        end
    end

    always_comb begin
        nxt          = state;
        pc_write     = 1'b0;
        pc_sel       = PC_PLUS4;
        ir_write     = 1'b0;
        alu_src_a    = A_RS1;
        alu_src_b    = B_RS2;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        // Nothing is requested while reset is held, even though state reads FETCH
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_sel   = PC_PLUS4;
                        nxt      = S_DECODE;
                    end else if (to_hit) begin
                        nxt = S_HALT;
                    end
                end
                S_DECODE: begin
                    nxt = legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    unique case (cls_q)
                        C_OP: begin
                            alu_src_a = A_RS1;
                            alu_src_b = B_RS2;
                        end
                        C_OPIMM, C_LOAD, C_STORE, C_JALR: begin
                            alu_src_a = A_RS1;
                            alu_src_b = B_IMM;
                        end
                        C_AUIPC, C_JAL, C_BRANCH: begin
                            alu_src_a = A_PC;
                            alu_src_b = B_IMM;
                        end
                        C_LUI: begin
                            alu_src_a = A_ZERO;
                            alu_src_b = B_IMM;
                        end
                        default: ;
                    endcase
                    if (cls_q == C_BRANCH) begin
                        pc_write = br_taken;
                        pc_sel   = PC_ALU;
                        nxt      = S_FETCH;
                    end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                        nxt = S_MEM;
                    end else begin
                        nxt = S_WB;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = ADDR_ALU;
                    mem_we       = (cls_q == C_STORE);
                    if (mem_ready)
                        nxt = (cls_q == C_STORE) ? S_FETCH : S_WB;
                    else if (to_hit)
                        nxt = S_HALT;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (cls_q == C_LOAD)
                        wb_sel = WB_MEM;
                    else if (cls_q == C_JAL || cls_q == C_JALR)
                        wb_sel = WB_PC4;
                    // Jump target sits in ALU-out since EXEC
                    if (cls_q == C_JAL || cls_q == C_JALR) begin
                        pc_write = 1'b1;
                        pc_sel   = PC_ALU;
                    end
                    nxt = S_FETCH;
                end
                S_HALT: nxt = S_HALT;
                default: nxt = S_FETCH;
            endcase
        end
    end

    assign imm_type = imm_q;
    assign trap     = trap_q;
    assign state_o  = state;

endmodule
